// File: rtl/time_date_counter.sv
// Time-of-day and Gregorian calendar counter advanced by a centisecond strobe, with validated load.
// Optional alarm comparator is compiled in when TIME_DATE_ALARM_EN is defined.
module time_date_counter #(
    parameter int TICKS_PER_SEC = 100,
    parameter int YEAR_RESET    = 1970,
    parameter int YEAR_W        = 15
) (
    input  logic              clockSignal,
    input  logic              resetN,
    input  logic              tick,
    input  logic              load,
    input  logic [4:0]        loadHours,
    input  logic [5:0]        loadMinutes,
    input  logic [5:0]        loadSeconds,
    input  logic [4:0]        loadDate,
    input  logic [3:0]        loadMonth,
    input  logic [YEAR_W-1:0] loadYear,
    input  logic [2:0]        loadDay,
`ifdef TIME_DATE_ALARM_EN
    input  logic              alarmArm,
    input  logic [4:0]        alarmHours,
    input  logic [5:0]        alarmMinutes,
    output logic              alarmMatch,
`endif
    output logic [6:0]        centiseconds,
    output logic [5:0]        seconds,
    output logic [5:0]        minutes,
    output logic [4:0]        hours,
    output logic [4:0]        date,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [2:0]        day,
    output logic              secondPulse,
    output logic              loadError
);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        return (y[1:0] == 2'd0) &&
               (((y % YEAR_W'(100)) != '0) || ((y % YEAR_W'(400)) == '0));
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return leap ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    // Carry chain: each stage wraps only when all lower stages wrap on this tick.
    logic [4:0] month_len;
    logic       cs_wrap, sec_wrap, min_wrap, hr_wrap, date_wrap, month_wrap;
    logic       load_ok;

    assign month_len  = days_in_month(month, is_leap(year));
    assign cs_wrap    = (centiseconds == 7'(TICKS_PER_SEC - 1));
    assign sec_wrap   = cs_wrap && (seconds == 6'd59);
    assign min_wrap   = sec_wrap && (minutes == 6'd59);
    assign hr_wrap    = min_wrap && (hours == 5'd23);
    assign date_wrap  = hr_wrap && (date == month_len);
    assign month_wrap = date_wrap && (month == 4'd12);

    assign load_ok = (loadHours <= 5'd23) && (loadMinutes <= 6'd59) && (loadSeconds <= 6'd59) &&
                     (loadMonth >= 4'd1) && (loadMonth <= 4'd12) && (loadDate >= 5'd1) &&
                     (loadDate <= days_in_month(loadMonth, is_leap(loadYear))) &&
                     (loadDay <= 3'd6);

    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            centiseconds <= '0;
            seconds      <= '0;
            minutes      <= '0;
            hours        <= '0;
            date         <= 5'd1;
            month        <= 4'd1;
            year         <= YEAR_W'(YEAR_RESET);
            day          <= 3'd4;
            secondPulse  <= 1'b0;
            loadError    <= 1'b0;
        end else begin
            secondPulse <= 1'b0;
            // Load has priority; a coincident tick is dropped, not deferred.
            if (load) begin
                loadError <= !load_ok;
                if (load_ok) begin
                    centiseconds <= '0;
                    seconds      <= loadSeconds;
                    minutes      <= loadMinutes;
                    hours        <= loadHours;
                    date         <= loadDate;
                    month        <= loadMonth;
                    year         <= loadYear;
                    day          <= loadDay;
                    secondPulse  <= 1'b1;
                end
            end else if (tick) begin
                centiseconds <= cs_wrap ? '0 : centiseconds + 7'd1;
                if (cs_wrap) begin
                    seconds     <= sec_wrap ? '0 : seconds + 6'd1;
                    secondPulse <= 1'b1;
                end
                if (sec_wrap) minutes <= min_wrap ? '0 : minutes + 6'd1;
                if (min_wrap) hours <= hr_wrap ? '0 : hours + 5'd1;
                if (hr_wrap) begin
                    date <= date_wrap ? 5'd1 : date + 5'd1;
                    day  <= (day == 3'd6) ? 3'd0 : day + 3'd1;
                end
                if (date_wrap) month <= month_wrap ? 4'd1 : month + 4'd1;
                if (month_wrap) year <= year + 1'b1;
            end
        end
    end

`ifdef TIME_DATE_ALARM_EN
    logic [5:0] next_min;
    logic [4:0] next_hr;
    logic       alarm_hit;

    assign next_min  = min_wrap ? '0 : minutes + 6'd1;
    assign next_hr   = hr_wrap ? '0 : (min_wrap ? hours + 5'd1 : hours);
    assign alarm_hit = alarmArm && (load ?
        (load_ok && (loadSeconds == 6'd0) && (loadHours == alarmHours) && (loadMinutes == alarmMinutes)) :
        (tick && sec_wrap && (next_hr == alarmHours) && (next_min == alarmMinutes)));

    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) alarmMatch <= 1'b0;
        else         alarmMatch <= alarm_hit;
    end
`endif

endmodule

// File: tb/tb_time_date_counter.sv
// Scoreboard bench for time_date_counter: stimulus queues expected snapshots, a negedge monitor compares.
module tb_time_date_counter;

    typedef struct packed {
        logic [6:0]  cs;
        logic [5:0]  sec;
        logic [5:0]  min;
        logic [4:0]  hr;
        logic [4:0]  date;
        logic [3:0]  mon;
        logic [14:0] year;
        logic [2:0]  day;
        logic        pulse;
        logic        err;
    } state_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        load = 1'b0;
    logic [4:0]  ld_hr = '0;
    logic [5:0]  ld_min = '0;
    logic [5:0]  ld_sec = '0;
    logic [4:0]  ld_date = '0;
    logic [3:0]  ld_mon = '0;
    logic [14:0] ld_year = '0;
    logic [2:0]  ld_day = '0;
    logic [6:0]  cs;
    logic [5:0]  sec, min;
    logic [4:0]  hr, date;
    logic [3:0]  mon;
    logic [14:0] year;
    logic [2:0]  dow;
    logic        pulse, err;
`ifdef TIME_DATE_ALARM_EN
    logic        alarm_arm = 1'b0;
    logic [4:0]  alarm_hr = '0;
    logic [5:0]  alarm_min = '0;
    logic        alarm_match;
`endif

    int checks = 0;
    int errors = 0;
    state_t exp_q[$];
    string  name_q[$];

    time_date_counter dut (
        .clockSignal(clk), .resetN(rst_n), .tick(tick), .load(load),
        .loadHours(ld_hr), .loadMinutes(ld_min), .loadSeconds(ld_sec), .loadDate(ld_date),
        .loadMonth(ld_mon), .loadYear(ld_year), .loadDay(ld_day),
`ifdef TIME_DATE_ALARM_EN
        .alarmArm(alarm_arm), .alarmHours(alarm_hr), .alarmMinutes(alarm_min), .alarmMatch(alarm_match),
`endif
        .centiseconds(cs), .seconds(sec), .minutes(min), .hours(hr), .date(date), .month(mon),
        .year(year), .day(dow), .secondPulse(pulse), .loadError(err)
    );

    always #5 clk = ~clk;

    // Monitor: compares every queued expectation against the outputs at the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            state_t e, a;
            string  nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '{cs, sec, min, hr, date, mon, year, dow, pulse, err};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %0d:%0d:%0d.%0d %0d/%0d/%0d day=%0d pulse=%0b err=%0b, want %0d:%0d:%0d.%0d %0d/%0d/%0d day=%0d pulse=%0b err=%0b",
                         nm, a.hr, a.min, a.sec, a.cs, a.date, a.mon, a.year, a.day, a.pulse, a.err,
                         e.hr, e.min, e.sec, e.cs, e.date, e.mon, e.year, e.day, e.pulse, e.err);
            end
        end
    end

    function automatic state_t mk(int h, int m, int s, int c, int d, int mo, int y, int dw, int p, int er);
        state_t st;
        st = '{7'(c), 6'(s), 6'(m), 5'(h), 5'(d), 4'(mo), 15'(y), 3'(dw), 1'(p), 1'(er)};
        return st;
    endfunction

    task automatic expect_st(input string nm, input state_t st);
        exp_q.push_back(st);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    task automatic step(input logic t, input int n);
        tick = t;
        repeat (n) @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic do_load(input int h, input int m, input int s, input int d, input int mo,
                           input int y, input int dw, input logic with_tick);
        ld_hr = 5'(h); ld_min = 6'(m); ld_sec = 6'(s); ld_date = 5'(d);
        ld_mon = 4'(mo); ld_year = 15'(y); ld_day = 3'(dw);
        load = 1'b1;
        tick = with_tick;
        @(posedge clk);
        #1 load = 1'b0;
        tick = 1'b0;
    endtask

`ifdef TIME_DATE_ALARM_EN
    task automatic chk_alarm(input string nm, input logic want);
        checks++;
        if (alarm_match !== want) begin
            errors++;
            $display("FAIL %s: alarmMatch got %0b want %0b", nm, alarm_match, want);
        end
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_st("reset", mk(0, 0, 0, 0, 1, 1, 1970, 4, 0, 0));

        step(1, 99);
        expect_st("t1_99ticks", mk(0, 0, 0, 99, 1, 1, 1970, 4, 0, 0));
        step(1, 1);
        expect_st("t1_1sec", mk(0, 0, 1, 0, 1, 1, 1970, 4, 1, 0));
        step(0, 1);
        expect_st("t1_pulse_drop", mk(0, 0, 1, 0, 1, 1, 1970, 4, 0, 0));

        do_load(23, 59, 59, 31, 12, 1999, 5, 1'b0);
        expect_st("t2_load", mk(23, 59, 59, 0, 31, 12, 1999, 5, 1, 0));
        step(1, 100);
        expect_st("t2_newyear", mk(0, 0, 0, 0, 1, 1, 2000, 6, 1, 0));

        do_load(23, 59, 59, 28, 2, 2000, 1, 1'b0);
        step(1, 100);
        expect_st("t3_leap2000", mk(0, 0, 0, 0, 29, 2, 2000, 2, 1, 0));
        do_load(23, 59, 59, 28, 2, 1900, 3, 1'b0);
        step(1, 100);
        expect_st("t3_noleap1900", mk(0, 0, 0, 0, 1, 3, 1900, 4, 1, 0));
        do_load(23, 59, 59, 28, 2, 2023, 2, 1'b0);
        step(1, 100);
        expect_st("t3_noleap2023", mk(0, 0, 0, 0, 1, 3, 2023, 3, 1, 0));

        do_load(12, 0, 0, 31, 4, 2024, 1, 1'b0);
        expect_st("t4_rej_apr31", mk(0, 0, 0, 0, 1, 3, 2023, 3, 0, 1));
        do_load(12, 0, 0, 29, 2, 2023, 1, 1'b0);
        expect_st("t4_rej_feb29", mk(0, 0, 0, 0, 1, 3, 2023, 3, 0, 1));
        do_load(24, 0, 0, 1, 1, 2024, 1, 1'b0);
        expect_st("t4_rej_hr24", mk(0, 0, 0, 0, 1, 3, 2023, 3, 0, 1));
        step(1, 1);
        expect_st("t4_err_holds", mk(0, 0, 0, 1, 1, 3, 2023, 3, 0, 1));
        do_load(12, 34, 56, 15, 6, 2024, 6, 1'b0);
        expect_st("t4_accept", mk(12, 34, 56, 0, 15, 6, 2024, 6, 1, 0));

        do_load(23, 59, 59, 30, 4, 2024, 2, 1'b0);
        step(1, 100);
        expect_st("apr30_wrap", mk(0, 0, 0, 0, 1, 5, 2024, 3, 1, 0));
        do_load(23, 59, 59, 31, 12, 32767, 0, 1'b0);
        step(1, 100);
        expect_st("year_wrap", mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 0));

        do_load(10, 0, 0, 1, 1, 2024, 1, 1'b1);
        expect_st("t5_load_beats_tick", mk(10, 0, 0, 0, 1, 1, 2024, 1, 1, 0));
        step(1, 5);
        expect_st("t5_5ticks", mk(10, 0, 0, 5, 1, 1, 2024, 1, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b0;
        expect_st("t5_async_reset", mk(0, 0, 0, 0, 1, 1, 1970, 4, 0, 0));
        step(1, 2);
        expect_st("t5_tick_in_reset", mk(0, 0, 0, 0, 1, 1, 1970, 4, 0, 0));
        rst_n = 1'b1;
        step(1, 3);
        expect_st("t5_after_reset", mk(0, 0, 0, 3, 1, 1, 1970, 4, 0, 0));

`ifdef TIME_DATE_ALARM_EN
        alarm_hr = 5'd7; alarm_min = 6'd30; alarm_arm = 1'b1;
        do_load(7, 29, 59, 1, 1, 2024, 1, 1'b0);
        chk_alarm("t6_after_load", 1'b0);
        step(1, 99);
        chk_alarm("t6_before", 1'b0);
        step(1, 1);
        chk_alarm("t6_match", 1'b1);
        step(0, 1);
        chk_alarm("t6_one_cycle", 1'b0);
        alarm_arm = 1'b0;
        do_load(7, 29, 59, 1, 1, 2024, 1, 1'b0);
        step(1, 100);
        chk_alarm("t6_disarmed", 1'b0);
        alarm_arm = 1'b1;
        do_load(7, 30, 0, 1, 1, 2024, 1, 1'b0);
        chk_alarm("t6_load_match", 1'b1);
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
